// File: rtl/haraka_aes_inv_round_iter_pkg.sv
// Shared definitions for the iterative inverse Haraka AES round engine:
// block type, FSM state encoding, forward/inverse AES S-boxes and the
// GF(2^8) constant multipliers (mod 0x11B) used by InvMixColumns.
package haraka_aes_inv_round_iter_pkg;

  localparam int unsigned BLOCK_W = 128;
  localparam int unsigned BYTE_W  = 8;

  typedef logic [BLOCK_W-1:0] block_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_e;

  localparam logic [7:0] AES_SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] AES_INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Multiply by x modulo 0x11B; stays 8 bits wide.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf256_mul_9(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ a;
  endfunction

  function automatic logic [7:0] gf256_mul_b(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
  endfunction

  function automatic logic [7:0] gf256_mul_d(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
  endfunction

  function automatic logic [7:0] gf256_mul_e(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
  endfunction

endpackage

// File: rtl/haraka_aes_inv_round.sv
// Combinational inverse keyed AES round, split into two halves so a caller
// can register between them.
//   state  : round input block (column-major, byte i = bits [8i+7:8i])
//   rk     : round key XORed in first
//   mix    : key-add followed by InvMixColumns of state
//   mix_in : block fed to the second half (mix, or a registered copy)
//   result : InvShiftRows then InvSubBytes of mix_in
module haraka_aes_inv_round
  import haraka_aes_inv_round_iter_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] rk,
  output logic [127:0] mix,
  input  logic [127:0] mix_in,
  output logic [127:0] result
);

  logic [127:0] keyed;

  // Key-add and InvMixColumns; coefficient row {0e,0b,0d,09} rotates per output row.
  always_comb begin
    keyed = state ^ rk;
    mix   = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        mix[BYTE_W*(4*c+r) +: BYTE_W] =
            gf256_mul_e(keyed[BYTE_W*(4*c+r)           +: BYTE_W]) ^
            gf256_mul_b(keyed[BYTE_W*(4*c+((r+1) % 4)) +: BYTE_W]) ^
            gf256_mul_d(keyed[BYTE_W*(4*c+((r+2) % 4)) +: BYTE_W]) ^
            gf256_mul_9(keyed[BYTE_W*(4*c+((r+3) % 4)) +: BYTE_W]);
      end
    end
  end

  // InvShiftRows (row r of column c comes from column c-r) then InvSubBytes.
  always_comb begin
    result = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        result[BYTE_W*(4*c+r) +: BYTE_W] =
            AES_INV_SBOX[mix_in[BYTE_W*(4*((c - r + 4) % 4) + r) +: BYTE_W]];
      end
    end
  end

endmodule

// File: rtl/haraka_aes_inv_round_iter.sv
// Iterative inverse Haraka AES round engine: undoes NUM_ROUNDS forward rounds
// on one 128-bit block, consuming round keys NUM_ROUNDS-1 down to 0.
// Optional build macro HARAKA_AES_INV_SPLIT_EN: each inverse round takes two
// RUN cycles (key-add + InvMixColumns, then InvShiftRows + InvSubBytes).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : block input handshake, in_data is the block
//   rk_idx / rk         : round-key index out, key returned same cycle
//   out_valid/out_ready : result handshake, out_data is the recovered block
//   busy                : high while rounds are being computed
module haraka_aes_inv_round_iter
  import haraka_aes_inv_round_iter_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS  = 10,
  parameter int unsigned ROUND_IDX_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [127:0]           in_data,
  output logic [ROUND_IDX_W-1:0] rk_idx,
  input  logic [127:0]           rk,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [127:0]           out_data,
  output logic                   busy
);

  fsm_e                   fsm, fsm_next;
  logic [ROUND_IDX_W-1:0] ctr;
  block_t                 state;
  block_t                 mix;
  block_t                 mix_in;
  block_t                 result;
  logic                   last_step;

  haraka_aes_inv_round u_round (
    .state  (state),
    .rk     (rk),
    .mix    (mix),
    .mix_in (mix_in),
    .result (result)
  );

`ifdef HARAKA_AES_INV_SPLIT_EN
  logic   phase;
  block_t mix_q;

  assign mix_in    = mix_q;
  assign last_step = (fsm == RUN) && phase && (ctr == '0);
`else
  assign mix_in    = mix;
  assign last_step = (fsm == RUN) && (ctr == '0);
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) fsm <= IDLE;
    else     fsm <= fsm_next;
  end

  // FSM next-state logic.
  always_comb begin
    fsm_next = fsm;
    case (fsm)
      IDLE:    if (in_valid)  fsm_next = RUN;
      RUN:     if (last_step) fsm_next = DONE;
      DONE:    if (out_ready) fsm_next = IDLE;
      default: fsm_next = IDLE;
    endcase
  end

  // FSM output decode; in_ready is also masked while reset is asserted.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    rk_idx   = '0;
    case (fsm)
      IDLE:    in_ready = !rst;
      RUN: begin
        busy   = 1'b1;
        rk_idx = ctr;
      end
      default: ;
    endcase
  end

  // Datapath: block state, round counter and registered result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= '0;
      ctr       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
`ifdef HARAKA_AES_INV_SPLIT_EN
      phase     <= 1'b0;
      mix_q     <= '0;
`endif
    end else begin
      out_valid <= (fsm_next == DONE);
      if (last_step) out_data <= result;

      if ((fsm == IDLE) && in_valid) begin
        state <= in_data;
        ctr   <= ROUND_IDX_W'(NUM_ROUNDS - 1);
`ifdef HARAKA_AES_INV_SPLIT_EN
        phase <= 1'b0;
`endif
      end else if (fsm == RUN) begin
`ifdef HARAKA_AES_INV_SPLIT_EN
        // Key is sampled only in phase 0; rk_idx stays put across both phases.
        if (!phase) begin
          mix_q <= mix;
          phase <= 1'b1;
        end else begin
          state <= result;
          phase <= 1'b0;
          if (ctr != '0) ctr <= ctr - ROUND_IDX_W'(1);
        end
`else
        state <= result;
        if (ctr != '0) ctr <= ctr - ROUND_IDX_W'(1);
`endif
      end
    end
  end

endmodule

// File: tb/tb_haraka_aes_inv_round_iter.sv
// Bench for haraka_aes_inv_round_iter: a one-round instance for the known
// answers and a ten-round instance checked against a forward-round model.
module tb_haraka_aes_inv_round_iter;
  import haraka_aes_inv_round_iter_pkg::*;

`ifdef HARAKA_AES_INV_SPLIT_EN
  localparam int PH = 2;
`else
  localparam int PH = 1;
`endif
  localparam int NR_B = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic         in_valid_a, in_ready_a, out_valid_a, out_ready_a, busy_a;
  logic [127:0] in_data_a, rk_a, out_data_a;
  logic [3:0]   rk_idx_a;

  logic         in_valid_b, in_ready_b, out_valid_b, out_ready_b, busy_b;
  logic [127:0] in_data_b, rk_b, out_data_b;
  logic [3:0]   rk_idx_b;

  logic [127:0] keys [16];
  assign rk_b = keys[rk_idx_b];

  haraka_aes_inv_round_iter #(.NUM_ROUNDS(1), .ROUND_IDX_W(4)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_data(in_data_a), .rk_idx(rk_idx_a), .rk(rk_a), .out_valid(out_valid_a),
    .out_ready(out_ready_a), .out_data(out_data_a), .busy(busy_a));

  haraka_aes_inv_round_iter #(.NUM_ROUNDS(NR_B), .ROUND_IDX_W(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_data(in_data_b), .rk_idx(rk_idx_b), .rk(rk_b), .out_valid(out_valid_b),
    .out_ready(out_ready_b), .out_data(out_data_b), .busy(busy_b));

  int tests = 0;
  int fails = 0;
  logic [127:0] q_a [$];
  logic [127:0] q_b [$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Forward Haraka AES round: SubBytes, ShiftRows, MixColumns, AddRoundKey.
  function automatic logic [127:0] fwd_round(input logic [127:0] s, input logic [127:0] k);
    logic [7:0] b [16];
    logic [7:0] sh [16];
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) b[i] = AES_SBOX[s[8*i +: 8]];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) sh[4*c+r] = b[4*((c+r) % 4) + r];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[8*(4*c+r) +: 8] = xt(sh[4*c+r]) ^ xt(sh[4*c+((r+1)%4)]) ^ sh[4*c+((r+1)%4)]
                          ^ sh[4*c+((r+2)%4)] ^ sh[4*c+((r+3)%4)];
    return o ^ k;
  endfunction

  function automatic logic [127:0] fwd_all(input logic [127:0] x);
    logic [127:0] s;
    s = x;
    for (int i = 0; i < NR_B; i++) s = fwd_round(s, keys[i]);
    return s;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic run_a(input logic [127:0] din, input logic [127:0] key,
                       input logic [127:0] exp, input string tag);
    int cnt;
    logic [127:0] e;
    in_data_a = din;
    rk_a = key;
    in_valid_a = 1'b1;
    q_a.push_back(exp);
    chk({tag, "_in_ready"}, 128'(in_ready_a), 128'(1));
    tick();
    in_valid_a = 1'b0;
    cnt = 1;
    chk({tag, "_busy"}, 128'(busy_a), 128'(1));
    while (!out_valid_a && cnt < 20) begin
      tick();
      cnt++;
    end
    chk({tag, "_latency"}, 128'(cnt), 128'(PH + 1));
    e = q_a.pop_front();
    chk({tag, "_data"}, out_data_a, e);
    out_ready_a = 1'b1;
    tick();
    out_ready_a = 1'b0;
    chk({tag, "_ovalid_clr"}, 128'(out_valid_a), 128'(0));
  endtask

  task automatic run_b(input logic [127:0] x, input string tag);
    logic [127:0] e;
    in_data_b = fwd_all(x);
    in_valid_b = 1'b1;
    q_b.push_back(x);
    chk({tag, "_in_ready"}, 128'(in_ready_b), 128'(1));
    tick();
    in_valid_b = 1'b0;
    for (int i = 0; i < PH*NR_B; i++) begin
      chk({tag, "_rk_idx"}, 128'(rk_idx_b), 128'(NR_B - 1 - i/PH));
      tick();
    end
    chk({tag, "_ovalid"}, 128'(out_valid_b), 128'(1));
    e = q_b.pop_front();
    chk({tag, "_data"}, out_data_b, e);
    out_ready_b = 1'b1;
    tick();
    out_ready_b = 1'b0;
    chk({tag, "_in_ready_after"}, 128'(in_ready_b), 128'(1));
    chk({tag, "_ovalid_after"}, 128'(out_valid_b), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, cyc, n_acc, n_out, t0, t1;
    logic acc, seen;
    logic [127:0] x0, x1, k, e;

    rst = 1'b1;
    in_valid_a = 1'b0; out_ready_a = 1'b0; in_data_a = '0; rk_a = '0;
    in_valid_b = 1'b0; out_ready_b = 1'b0; in_data_b = '0;
    for (int i = 0; i < 16; i++) keys[i] = rnd128();

    // Reset values
    tick();
    chk("rst_in_ready", 128'(in_ready_a), 128'(0));
    chk("rst_out_valid", 128'(out_valid_a), 128'(0));
    chk("rst_out_data", out_data_a, 128'(0));
    chk("rst_rk_idx", 128'(rk_idx_b), 128'(0));
    chk("rst_busy", 128'(busy_b), 128'(0));
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready_a", 128'(in_ready_a), 128'(1));
    chk("post_rst_in_ready_b", 128'(in_ready_b), 128'(1));

    // One-round known answers and a random single-round inversion
    run_a({16{8'h63}}, '0, '0, "a_63");
    run_a('0, '0, {16{8'h52}}, "a_00");
    run_a('0, {16{8'h63}}, '0, "a_key63");
    x0 = rnd128();
    k  = rnd128();
    run_a(fwd_round(x0, k), k, x0, "a_rand");

    // Ten-round round trips against the forward model
    for (int n = 0; n < 3; n++) run_b(rnd128(), "b_trip");

    // Back-to-back blocks with out_ready held high
    x0 = rnd128();
    x1 = rnd128();
    out_ready_b = 1'b1;
    in_valid_b = 1'b1;
    in_data_b = fwd_all(x0);
    q_b.push_back(x0);
    cyc = 0; n_acc = 0; n_out = 0; t0 = 0; t1 = 0;
    while (n_out < 2 && cyc < 200) begin
      acc = in_valid_b && in_ready_b;
      if (out_valid_b) begin
        chk("tput_no_accept_on_out", 128'(in_ready_b), 128'(0));
        e = (q_b.size() > 0) ? q_b.pop_front() : '1;
        chk("tput_data", out_data_b, e);
        if (n_out == 0) t0 = cyc;
        else t1 = cyc;
        n_out++;
      end
      tick();
      cyc++;
      if (acc) begin
        n_acc++;
        if (n_acc == 1) begin
          in_data_b = fwd_all(x1);
          q_b.push_back(x1);
        end else begin
          in_valid_b = 1'b0;
        end
      end
    end
    in_valid_b = 1'b0;
    out_ready_b = 1'b0;
    chk("tput_outputs", 128'(n_out), 128'(2));
    chk("tput_interval", 128'(t1 - t0), 128'(PH*NR_B + 2));

    // Back-pressure: DONE held for 20 cycles
    x0 = rnd128();
    in_data_b = fwd_all(x0);
    in_valid_b = 1'b1;
    q_b.push_back(x0);
    tick();
    in_valid_b = 1'b0;
    cnt = 0;
    while (!out_valid_b && cnt < 50) begin
      tick();
      cnt++;
    end
    e = q_b.pop_front();
    chk("bp_data", out_data_b, e);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("bp_out_valid", 128'(out_valid_b), 128'(1));
      chk("bp_out_data", out_data_b, e);
      chk("bp_in_ready", 128'(in_ready_b), 128'(0));
    end
    out_ready_b = 1'b1;
    tick();
    out_ready_b = 1'b0;
    chk("bp_release_in_ready", 128'(in_ready_b), 128'(1));
    chk("bp_release_out_valid", 128'(out_valid_b), 128'(0));

    // Reset while in RUN with counter at 5: block is dropped
    in_data_b = rnd128();
    in_valid_b = 1'b1;
    tick();
    in_valid_b = 1'b0;
    cnt = 0;
    while (rk_idx_b !== 4'd5 && cnt < 50) begin
      tick();
      cnt++;
    end
    chk("midrst_reached_ctr5", 128'(rk_idx_b), 128'(5));
    rst = 1'b1;
    tick();
    chk("midrst_in_ready", 128'(in_ready_b), 128'(0));
    chk("midrst_out_valid", 128'(out_valid_b), 128'(0));
    chk("midrst_out_data", out_data_b, 128'(0));
    chk("midrst_rk_idx", 128'(rk_idx_b), 128'(0));
    chk("midrst_busy", 128'(busy_b), 128'(0));
    rst = 1'b0;
    #1;
    chk("midrst_idle_in_ready", 128'(in_ready_b), 128'(1));
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (out_valid_b || busy_b) seen = 1'b1;
      tick();
    end
    chk("midrst_no_output", 128'(seen), 128'(0));
    chk("scoreboard_empty", 128'(q_a.size() + q_b.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
